// File: rtl/wb_soc_interface_master_pkg.sv
// Shared definitions for the Wishbone-to-byte-stream SoC interface master:
// command/response codes, FSM state encoding and byte-lane helpers.
// Both the master and its slave counterpart import this package so the
// packet codes can only change in one place.
package wb_soc_interface_master_pkg;

    // Command header high nibble; low nibble carries the byte-lane selects
    localparam logic [3:0] CMD_RD_NIB = 4'hA;
    localparam logic [3:0] CMD_WR_NIB = 4'hB;

    // Response header bytes
    localparam logic [7:0] RSP_RD_HDR = 8'hA1;
    localparam logic [7:0] RSP_WR_HDR = 8'hB1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_HDR   = 3'd1,
        ST_TX_ADDR  = 3'd2,
        ST_TX_DATA  = 3'd3,
        ST_RX_HDR   = 3'd4,
        ST_RX_DATA  = 3'd5,
        ST_RX_DRAIN = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Byte idx of a word, counted MSB first (idx 0 = bits 31:24)
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // First byte of a command packet
    function automatic logic [7:0] cmd_header(input logic we, input logic [3:0] sel);
        return {(we ? CMD_WR_NIB : CMD_RD_NIB), sel};
    endfunction

endpackage

// File: rtl/wb_soc_interface_master.sv
// Wishbone classic slave that tunnels each bus access over a pair of
// AXI-Stream byte links: the access is serialised into a command packet,
// the matching response packet is parsed, and the bus cycle is terminated
// with a one-cycle ack (success) or err (bad/short/missing response).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wb_*                Wishbone classic slave (adr/dat/we/sel/stb/cyc in,
//                       dat/ack/err out)
//   output_axis_*       command byte stream (registered tdata/tvalid/tlast)
//   input_axis_*        response byte stream
//   busy                high whenever the FSM is not idle
module wb_soc_interface_master
    import wb_soc_interface_master_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [7:0]  output_axis_tdata,
    output logic        output_axis_tvalid,
    input  logic        output_axis_tready,
    output logic        output_axis_tlast,
    input  logic [7:0]  input_axis_tdata,
    input  logic        input_axis_tvalid,
    output logic        input_axis_tready,
    input  logic        input_axis_tlast,
    output logic        busy
);

    // Counter only needs to hold 0..TIMEOUT-1; hitting TIMEOUT-1 ends the wait
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state_r;
    logic [1:0]        cnt_r;
    logic [TMO_W-1:0]  tmo_r;
    logic [31:0]       adr_r;
    logic [31:0]       dat_r;
    logic              we_r;
    logic [23:0]       shift_r;
    logic [31:0]       rdata_r;
    logic [7:0]        tx_data_r;
    logic              tx_valid_r;
    logic              tx_last_r;
    logic              rx_ready_r;
    logic              ack_r;
    logic              err_r;
    logic              cyc_lost_r;

    logic              tx_fire_s;
    logic              rx_fire_s;
    logic              tmo_hit_s;
    logic              live_s;
    logic              rx_done_s;
    logic              rx_ok_s;
    logic              rx_to_data_s;
    logic              rx_to_drain_s;

    assign tx_fire_s = tx_valid_r & output_axis_tready;
    assign rx_fire_s = input_axis_tvalid & rx_ready_r;
    assign tmo_hit_s = (tmo_r == TMO_LAST);
    // The requester is still waiting only if cyc never dropped during the exchange
    assign live_s    = wb_cyc_i & ~cyc_lost_r;

    assign wb_dat_o           = rdata_r;
    assign wb_ack_o           = ack_r;
    assign wb_err_o           = err_r;
    assign output_axis_tdata  = tx_data_r;
    assign output_axis_tvalid = tx_valid_r;
    assign output_axis_tlast  = tx_last_r;
    assign input_axis_tready  = rx_ready_r;
    assign busy               = (state_r != ST_IDLE);

    // Response parser: decides how the current RX cycle ends the state
    always_comb begin
        rx_done_s     = 1'b0;
        rx_ok_s       = 1'b0;
        rx_to_data_s  = 1'b0;
        rx_to_drain_s = 1'b0;
        case (state_r)
            ST_RX_HDR: begin
                if (tmo_hit_s) begin
                    rx_done_s = 1'b1;
                end else if (rx_fire_s) begin
                    if ((input_axis_tdata == RSP_WR_HDR) && input_axis_tlast && we_r) begin
                        rx_done_s = 1'b1;
                        rx_ok_s   = 1'b1;
                    end else if ((input_axis_tdata == RSP_RD_HDR) && !input_axis_tlast && !we_r) begin
                        rx_to_data_s = 1'b1;
                    end else if (input_axis_tlast) begin
                        rx_done_s = 1'b1;
                    end else begin
                        rx_to_drain_s = 1'b1;
                    end
                end else begin
                    rx_done_s = 1'b0;
                end
            end
            ST_RX_DATA: begin
                if (tmo_hit_s) begin
                    rx_done_s = 1'b1;
                end else if (rx_fire_s) begin
                    if (cnt_r == 2'd3) begin
                        rx_done_s     = input_axis_tlast;
                        rx_ok_s       = input_axis_tlast;
                        rx_to_drain_s = ~input_axis_tlast;
                    end else begin
                        // Early tlast means a truncated payload
                        rx_done_s = input_axis_tlast;
                    end
                end else begin
                    rx_done_s = 1'b0;
                end
            end
            ST_RX_DRAIN: begin
                if (tmo_hit_s) begin
                    rx_done_s = 1'b1;
                end else begin
                    rx_done_s = rx_fire_s & input_axis_tlast;
                end
            end
            default: rx_done_s = 1'b0;
        endcase
    end

    // Remembers that the requester abandoned the cycle mid-transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_lost_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            cyc_lost_r <= 1'b0;
        end else if (!wb_cyc_i) begin
            cyc_lost_r <= 1'b1;
        end else begin
            cyc_lost_r <= cyc_lost_r;
        end
    end

    // Main FSM: command serialiser, response capture and bus termination
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 2'd0;
            tmo_r      <= '0;
            adr_r      <= 32'h0;
            dat_r      <= 32'h0;
            we_r       <= 1'b0;
            shift_r    <= 24'h0;
            rdata_r    <= 32'h0;
            tx_data_r  <= 8'h0;
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
            rx_ready_r <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 1'b0;
                    err_r <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_r      <= wb_adr_i;
                        dat_r      <= wb_dat_i;
                        we_r       <= wb_we_i;
                        tx_data_r  <= cmd_header(wb_we_i, wb_sel_i);
                        tx_valid_r <= 1'b1;
                        tx_last_r  <= 1'b0;
                        rx_ready_r <= 1'b0;
                        state_r    <= ST_TX_HDR;
                    end else begin
                        // Stray response bytes are swallowed while idle
                        rx_ready_r <= 1'b1;
                    end
                end
                ST_TX_HDR: begin
                    if (tx_fire_s) begin
                        tx_data_r <= word_byte(adr_r, 2'd0);
                        tx_last_r <= 1'b0;
                        cnt_r     <= 2'd0;
                        state_r   <= ST_TX_ADDR;
                    end else begin
                        state_r <= ST_TX_HDR;
                    end
                end
                ST_TX_ADDR: begin
                    if (tx_fire_s && (cnt_r == 2'd3)) begin
                        if (we_r) begin
                            tx_data_r <= word_byte(dat_r, 2'd0);
                            tx_last_r <= 1'b0;
                            cnt_r     <= 2'd0;
                            state_r   <= ST_TX_DATA;
                        end else begin
                            tx_valid_r <= 1'b0;
                            tx_last_r  <= 1'b0;
                            tx_data_r  <= 8'h0;
                            tmo_r      <= '0;
                            rx_ready_r <= 1'b1;
                            state_r    <= ST_RX_HDR;
                        end
                    end else if (tx_fire_s) begin
                        cnt_r     <= cnt_r + 2'd1;
                        tx_data_r <= word_byte(adr_r, cnt_r + 2'd1);
                        // A read packet ends on the last address byte
                        tx_last_r <= ~we_r & (cnt_r == 2'd2);
                    end else begin
                        state_r <= ST_TX_ADDR;
                    end
                end
                ST_TX_DATA: begin
                    if (tx_fire_s && (cnt_r == 2'd3)) begin
                        tx_valid_r <= 1'b0;
                        tx_last_r  <= 1'b0;
                        tx_data_r  <= 8'h0;
                        tmo_r      <= '0;
                        rx_ready_r <= 1'b1;
                        state_r    <= ST_RX_HDR;
                    end else if (tx_fire_s) begin
                        cnt_r     <= cnt_r + 2'd1;
                        tx_data_r <= word_byte(dat_r, cnt_r + 2'd1);
                        tx_last_r <= (cnt_r == 2'd2);
                    end else begin
                        state_r <= ST_TX_DATA;
                    end
                end
                ST_RX_HDR, ST_RX_DATA, ST_RX_DRAIN: begin
                    tmo_r <= tmo_r + TMO_W'(1);
                    if ((state_r == ST_RX_DATA) && rx_fire_s) begin
                        shift_r <= {shift_r[15:0], input_axis_tdata};
                        cnt_r   <= cnt_r + 2'd1;
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (rx_done_s) begin
                        // Read data is only committed once the whole payload is good
                        if (rx_ok_s && (state_r == ST_RX_DATA)) begin
                            rdata_r <= {shift_r, input_axis_tdata};
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        ack_r      <= live_s & rx_ok_s;
                        err_r      <= live_s & ~rx_ok_s;
                        rx_ready_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end else if (rx_to_data_s) begin
                        cnt_r   <= 2'd0;
                        state_r <= ST_RX_DATA;
                    end else if (rx_to_drain_s) begin
                        state_r <= ST_RX_DRAIN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DONE: begin
                    ack_r      <= 1'b0;
                    err_r      <= 1'b0;
                    rx_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ack_r      <= 1'b0;
                    err_r      <= 1'b0;
                    tx_valid_r <= 1'b0;
                    tx_last_r  <= 1'b0;
                    rx_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
